// File: rtl/cpm_pkg.sv
// Shared types for the top-K sorter: controller states and key compare direction.
package cpm_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2
  } state_e;

  typedef enum logic {
    CmpMax = 1'b0,
    CmpMin = 1'b1
  } cmp_mode_e;

endpackage

// File: rtl/cpm_topk_cmp.sv
// One list-slot comparator: does the incoming key displace this slot?
// Strict comparison keeps equal keys in arrival order; an empty slot always loses.
module cpm_topk_cmp
  import cpm_pkg::*;
#(
  parameter int DATA_DW    = 8,
  parameter bit KEY_SIGNED = 1'b0
) (
  input  logic [DATA_DW-1:0] new_dat,
  input  logic [DATA_DW-1:0] slot_dat,
  input  logic               slot_occ,
  input  cmp_mode_e          mode,
  output logic               wins
);

  logic gt;
  logic lt;

  always_comb begin
    if (KEY_SIGNED) begin
      gt = $signed(new_dat) > $signed(slot_dat);
      lt = $signed(new_dat) < $signed(slot_dat);
    end else begin
      gt = new_dat > slot_dat;
      lt = new_dat < slot_dat;
    end
    wins = !slot_occ || ((mode == CmpMin) ? lt : gt);
  end

endmodule

// File: rtl/cpm_topk_sorter.sv
// Streaming top-K sorter: keeps the K best keys of a frame in a sorted shift list,
// then exposes them in parallel and drains them serially, best first.
module cpm_topk_sorter
  import cpm_pkg::*;
#(
  parameter int  DATA_DW    = 8,
  parameter int  INFO_DW    = 8,
  parameter int  TOPK       = 32,
  parameter bit  KEY_SIGNED = 1'b0,
  localparam int CNT_AW     = $clog2(TOPK + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    cfg_min,
  input  logic                    SORT_DAT_VLD,
  output logic                    SORT_DAT_RDY,
  input  logic                    SORT_DAT_LST,
  input  logic [DATA_DW-1:0]      SORT_DAT_DAT,
  input  logic [INFO_DW-1:0]      SORT_DAT_INF,
  output logic                    TOPK_DAT_VLD,
  output logic [CNT_AW-1:0]       TOPK_DAT_CNT,
  output logic [TOPK*DATA_DW-1:0] TOPK_DAT_DAT,
  output logic [TOPK*INFO_DW-1:0] TOPK_DAT_INF,
  output logic                    OUT_VLD,
  input  logic                    OUT_RDY,
  output logic                    OUT_LST,
  output logic [DATA_DW-1:0]      OUT_DAT,
  output logic [INFO_DW-1:0]      OUT_INF
);

  localparam int IDX_AW = $clog2(TOPK);

  state_e                 state_q, state_d;
  cmp_mode_e              mode_q, mode_d, mode_cur;
  logic [DATA_DW-1:0]     dat_q [TOPK];
  logic [DATA_DW-1:0]     dat_d [TOPK];
  logic [DATA_DW-1:0]     dat_eff [TOPK];
  logic [DATA_DW-1:0]     dat_prev [TOPK];
  logic [DATA_DW-1:0]     dat_ins [TOPK];
  logic [INFO_DW-1:0]     inf_q [TOPK];
  logic [INFO_DW-1:0]     inf_d [TOPK];
  logic [INFO_DW-1:0]     inf_eff [TOPK];
  logic [INFO_DW-1:0]     inf_prev [TOPK];
  logic [INFO_DW-1:0]     inf_ins [TOPK];
  logic [TOPK-1:0]        occ_q, occ_d, occ_eff, occ_prev, occ_ins;
  logic [TOPK-1:0]        wins, found_below;
  logic [CNT_AW-1:0]      cnt_q, cnt_d, cnt_last;
  logic [IDX_AW-1:0]      rd_q, rd_d;
  logic                   accept, first, out_hs;

  assign SORT_DAT_RDY = (state_q != StDrain);
  assign accept       = SORT_DAT_VLD && SORT_DAT_RDY;
  assign first        = (state_q == StIdle);
  assign mode_cur     = first ? (cfg_min ? CmpMin : CmpMax) : mode_q;

  // The first beat of a frame sees an empty list, so it lands in slot 0 regardless of old data.
  for (genvar g = 0; g < TOPK; g++) begin : g_slot
    assign dat_eff[g] = first ? '0 : dat_q[g];
    assign inf_eff[g] = first ? '0 : inf_q[g];
    assign occ_eff[g] = !first && occ_q[g];

    if (g == 0) begin : g_head
      assign dat_prev[g] = '0;
      assign inf_prev[g] = '0;
      assign occ_prev[g] = 1'b0;
    end else begin : g_tail
      assign dat_prev[g] = dat_eff[g-1];
      assign inf_prev[g] = inf_eff[g-1];
      assign occ_prev[g] = occ_eff[g-1];
    end

    cpm_topk_cmp #(
      .DATA_DW    (DATA_DW),
      .KEY_SIGNED (KEY_SIGNED)
    ) u_cmp (
      .new_dat  (SORT_DAT_DAT),
      .slot_dat (dat_eff[g]),
      .slot_occ (occ_eff[g]),
      .mode     (mode_cur),
      .wins     (wins[g])
    );

    // Slots below the insert point shift down; the insert point takes the new beat.
    assign dat_ins[g] = found_below[g] ? dat_prev[g] : (wins[g] ? SORT_DAT_DAT : dat_eff[g]);
    assign inf_ins[g] = found_below[g] ? inf_prev[g] : (wins[g] ? SORT_DAT_INF : inf_eff[g]);
    assign occ_ins[g] = found_below[g] ? occ_prev[g] : (wins[g] || occ_eff[g]);

    assign TOPK_DAT_DAT[g*DATA_DW +: DATA_DW] = dat_q[g];
    assign TOPK_DAT_INF[g*INFO_DW +: INFO_DW] = inf_q[g];
  end

  always_comb begin
    logic found;
    found = 1'b0;
    for (int i = 0; i < TOPK; i++) begin
      found_below[i] = found;
      found          = found || wins[i];
    end
  end

  assign OUT_VLD      = (state_q == StDrain);
  assign TOPK_DAT_VLD = OUT_VLD;
  assign TOPK_DAT_CNT = cnt_q;
  assign cnt_last     = cnt_q - CNT_AW'(1);
  assign OUT_LST      = OUT_VLD && (CNT_AW'(rd_q) == cnt_last);
  assign OUT_DAT      = OUT_VLD ? dat_q[rd_q] : '0;
  assign OUT_INF      = OUT_VLD ? inf_q[rd_q] : '0;
  assign out_hs       = OUT_VLD && OUT_RDY;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dat_d   = dat_q;
    inf_d   = inf_q;
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (clear) begin
      state_d = StIdle;
      occ_d   = '0;
      cnt_d   = '0;
      rd_d    = '0;
      for (int i = 0; i < TOPK; i++) begin
        dat_d[i] = '0;
        inf_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dat_d   = dat_ins;
            inf_d   = inf_ins;
            occ_d   = occ_ins;
            cnt_d   = CNT_AW'(1);
            rd_d    = '0;
            mode_d  = cfg_min ? CmpMin : CmpMax;
            state_d = SORT_DAT_LST ? StDrain : StFill;
          end
        end
        StFill: begin
          if (accept) begin
            dat_d = dat_ins;
            inf_d = inf_ins;
            occ_d = occ_ins;
            cnt_d = (cnt_q == CNT_AW'(TOPK)) ? cnt_q : cnt_q + CNT_AW'(1);
            if (SORT_DAT_LST) state_d = StDrain;
          end
        end
        StDrain: begin
          if (out_hs) begin
            if (OUT_LST) begin
              state_d = StIdle;
              rd_d    = '0;
            end else begin
              rd_d = rd_q + IDX_AW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= CmpMax;
      occ_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < TOPK; i++) begin
        dat_q[i] <= '0;
        inf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      dat_q   <= dat_d;
      inf_q   <= inf_d;
    end
  end

endmodule

// File: tb/tb_cpm_topk_sorter.sv
// Directed bench for cpm_topk_sorter with TOPK=4 and signed keys: frame vectors from a
// table plus hand sequences for back-pressure, clear and reset.
module tb_cpm_topk_sorter;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int K  = 4;
  localparam int CW = $clog2(K + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            cfg_min = 1'b0;
  logic            sort_vld = 1'b0;
  logic            sort_rdy;
  logic            sort_lst = 1'b0;
  logic [DW-1:0]   sort_dat = '0;
  logic [IW-1:0]   sort_inf = '0;
  logic            topk_vld;
  logic [CW-1:0]   topk_cnt;
  logic [K*DW-1:0] topk_dat;
  logic [K*IW-1:0] topk_inf;
  logic            out_vld;
  logic            out_rdy = 1'b1;
  logic            out_lst;
  logic [DW-1:0]   out_dat;
  logic [IW-1:0]   out_inf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cpm_topk_sorter #(
    .DATA_DW    (DW),
    .INFO_DW    (IW),
    .TOPK       (K),
    .KEY_SIGNED (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .cfg_min      (cfg_min),
    .SORT_DAT_VLD (sort_vld),
    .SORT_DAT_RDY (sort_rdy),
    .SORT_DAT_LST (sort_lst),
    .SORT_DAT_DAT (sort_dat),
    .SORT_DAT_INF (sort_inf),
    .TOPK_DAT_VLD (topk_vld),
    .TOPK_DAT_CNT (topk_cnt),
    .TOPK_DAT_DAT (topk_dat),
    .TOPK_DAT_INF (topk_inf),
    .OUT_VLD      (out_vld),
    .OUT_RDY      (out_rdy),
    .OUT_LST      (out_lst),
    .OUT_DAT      (out_dat),
    .OUT_INF      (out_inf)
  );

  typedef struct {
    logic            mn;
    int              n;
    logic [4:0][7:0] key;
    logic [4:0][7:0] inf;
    int              cnt;
    logic [3:0][7:0] ed;
    logic [3:0][7:0] ei;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rdy"}, 32'(sort_rdy), 32'd1);
    chk({tag, " topk_vld"}, 32'(topk_vld), 32'd0);
    chk({tag, " cnt"}, 32'(topk_cnt), 32'd0);
    chk({tag, " topk_dat"}, topk_dat, 32'd0);
    chk({tag, " topk_inf"}, topk_inf, 32'd0);
    chk({tag, " out_vld"}, 32'(out_vld), 32'd0);
    chk({tag, " out_lst"}, 32'(out_lst), 32'd0);
    chk({tag, " out_dat"}, 32'(out_dat), 32'd0);
    chk({tag, " out_inf"}, 32'(out_inf), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge where the list is in DRAIN.
  // cfg_min is inverted after the first beat: it must not affect the frame.
  task automatic send_frame(input vec_t v);
    for (int b = 0; b < v.n; b++) begin
      sort_vld = 1'b1;
      sort_dat = v.key[b];
      sort_inf = v.inf[b];
      sort_lst = (b == v.n - 1);
      cfg_min  = (b == 0) ? v.mn : ~v.mn;
      @(negedge clk);
    end
    sort_vld = 1'b0;
    sort_lst = 1'b0;
  endtask

  task automatic drain_frame(input vec_t v, input int stall_at, input string tag);
    chk({tag, " topk_vld"}, 32'(topk_vld), 32'd1);
    chk({tag, " cnt"}, 32'(topk_cnt), 32'(v.cnt));
    for (int i = 0; i < v.cnt; i++) begin
      chk($sformatf("%s par_dat[%0d]", tag, i), 32'(topk_dat[i*DW +: DW]), 32'(v.ed[i]));
      chk($sformatf("%s par_inf[%0d]", tag, i), 32'(topk_inf[i*IW +: IW]), 32'(v.ei[i]));
    end
    out_rdy = 1'b1;
    for (int k = 0; k < v.cnt; k++) begin
      chk($sformatf("%s out_vld[%0d]", tag, k), 32'(out_vld), 32'd1);
      chk($sformatf("%s out_dat[%0d]", tag, k), 32'(out_dat), 32'(v.ed[k]));
      chk($sformatf("%s out_inf[%0d]", tag, k), 32'(out_inf), 32'(v.ei[k]));
      chk($sformatf("%s out_lst[%0d]", tag, k), 32'(out_lst), 32'(k == v.cnt - 1));
      chk($sformatf("%s sort_rdy[%0d]", tag, k), 32'(sort_rdy), 32'd0);
      if (k == stall_at) begin
        out_rdy  = 1'b0;
        sort_vld = 1'b1;
        sort_dat = 8'h7f;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk($sformatf("%s stall%0d vld", tag, s), 32'(out_vld), 32'd1);
          chk($sformatf("%s stall%0d dat", tag, s), 32'(out_dat), 32'(v.ed[k]));
          chk($sformatf("%s stall%0d inf", tag, s), 32'(out_inf), 32'(v.ei[k]));
          chk($sformatf("%s stall%0d rdy", tag, s), 32'(sort_rdy), 32'd0);
          chk($sformatf("%s stall%0d cnt", tag, s), 32'(topk_cnt), 32'(v.cnt));
        end
        sort_vld = 1'b0;
        out_rdy  = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, " idle out_vld"}, 32'(out_vld), 32'd0);
    chk({tag, " idle rdy"}, 32'(sort_rdy), 32'd1);
    chk({tag, " idle topk_vld"}, 32'(topk_vld), 32'd0);
  endtask

  initial begin
    // max, ties stable: 5,9,3,9,7
    vecs[0] = '{mn: 1'b0, n: 5, key: {8'h07, 8'h09, 8'h03, 8'h09, 8'h05},
                inf: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, cnt: 4,
                ed: {8'h05, 8'h07, 8'h09, 8'h09}, ei: {8'h01, 8'h05, 8'h04, 8'h02}};
    // min, signed: -2,4,-8
    vecs[1] = '{mn: 1'b1, n: 3, key: {8'h00, 8'h00, 8'hf8, 8'h04, 8'hfe},
                inf: {8'h00, 8'h00, 8'ha3, 8'ha2, 8'ha1}, cnt: 3,
                ed: {8'h00, 8'h04, 8'hfe, 8'hf8}, ei: {8'h00, 8'ha2, 8'ha1, 8'ha3}};
    // single beat
    vecs[2] = '{mn: 1'b0, n: 1, key: {8'h00, 8'h00, 8'h00, 8'h00, 8'h11},
                inf: {8'h00, 8'h00, 8'h00, 8'h00, 8'h55}, cnt: 1,
                ed: {8'h00, 8'h00, 8'h00, 8'h11}, ei: {8'h00, 8'h00, 8'h00, 8'h55}};
    // min with overflow and a tie: 3,3,1,7,0 -> 0,1,3,3 (7 dropped)
    vecs[3] = '{mn: 1'b1, n: 5, key: {8'h00, 8'h07, 8'h01, 8'h03, 8'h03},
                inf: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, cnt: 4,
                ed: {8'h03, 8'h03, 8'h01, 8'h00}, ei: {8'h02, 8'h01, 8'h03, 8'h05}};
    // used after a cleared partial frame
    vecs[4] = '{mn: 1'b0, n: 2, key: {8'h00, 8'h00, 8'h00, 8'h02, 8'h01},
                inf: {8'h00, 8'h00, 8'h00, 8'hb2, 8'hb1}, cnt: 2,
                ed: {8'h00, 8'h00, 8'h01, 8'h02}, ei: {8'h00, 8'h00, 8'hb1, 8'hb2}};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v]);
      drain_frame(vecs[v], -1, $sformatf("vec%0d", v));
    end

    // Back-pressure mid-drain
    send_frame(vecs[0]);
    drain_frame(vecs[0], 1, "stall");

    // Clear after two beats of a frame
    sort_vld = 1'b1;
    cfg_min  = 1'b0;
    sort_dat = 8'h10; sort_inf = 8'hc1;
    @(negedge clk);
    sort_dat = 8'h20; sort_inf = 8'hc2;
    @(negedge clk);
    chk("fill cnt", 32'(topk_cnt), 32'd2);
    sort_vld = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear cnt", 32'(topk_cnt), 32'd0);
    chk("clear rdy", 32'(sort_rdy), 32'd1);
    chk("clear topk_vld", 32'(topk_vld), 32'd0);
    send_frame(vecs[4]);
    drain_frame(vecs[4], -1, "after_clear");

    // Clear during drain
    send_frame(vecs[2]);
    chk("drain out_vld", 32'(out_vld), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_drain out_vld", 32'(out_vld), 32'd0);
    chk("clear_drain rdy", 32'(sort_rdy), 32'd1);
    chk("clear_drain cnt", 32'(topk_cnt), 32'd0);

    // Reset during drain
    send_frame(vecs[0]);
    chk("pre_rst out_vld", 32'(out_vld), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_drain");
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
